// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory read port and datapath delivery port of the fetch stage.
// master = fetch stage side, slave = memory/datapath side.
interface fetch_queue_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_valid_i;
  logic [31:0] imem_instr_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic [31:0] inst_pc4_o;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_valid_i, imem_instr_i,
    output inst_valid_o, inst_o, inst_pc_o, inst_pc4_o,
    input  inst_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_valid_i, imem_instr_i,
    input  inst_valid_o, inst_o, inst_pc_o, inst_pc4_o,
    output inst_ready_i
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: owns fetch PC, one outstanding imem read, DEPTH-entry PC-tagged FIFO; 1-cycle mem -> inst_valid_o 2 cycles after request.
// Backpressure: stops requesting while count+push would reach DEPTH. FETCH_ALIGN_CHECK_EN: misaligned redirect -> sticky err_o + HALT.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          redirect_i,
  input  logic [31:0]   redirect_pc_i,
  fetch_queue_if.master fq,
  output logic          err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, WAIT, HALT} state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          discard_q, discard_d;
  logic          err_q, err_d;
  entry_t        fifo_q [DEPTH];
  entry_t        fifo_d [DEPTH];

  logic [31:0]   tgt_pc;
  logic          tgt_bad;
  logic          redirect;
  logic          resp;
  logic          push;
  logic          pop;
  logic          can_issue;
  logic          req;
  logic          inst_vld;
  entry_t        head;

`ifdef FETCH_ALIGN_CHECK_EN
  assign tgt_pc  = redirect_pc_i;
  assign tgt_bad = |redirect_pc_i[1:0];
`else
  logic [1:0] unused_pc_lsbs;
  assign unused_pc_lsbs = redirect_pc_i[1:0];
  assign tgt_pc  = {redirect_pc_i[31:2], 2'b00};
  assign tgt_bad = 1'b0;
`endif

  assign redirect  = redirect_i && (state_q != HALT);
  assign resp      = fq.imem_valid_i && (state_q == WAIT);
  assign push      = resp && !discard_q && !redirect;
  assign inst_vld  = (count_q != '0) && (state_q != HALT);
  assign pop       = inst_vld && fq.inst_ready_i;
  // A same-cycle pop does not free a slot for this cycle's issue decision.
  assign can_issue = (count_q + CW'(push)) < CW'(DEPTH);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    discard_d  = discard_q;
    err_d      = err_q;
    fifo_d     = fifo_q;
    req        = 1'b0;

    if (redirect) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = tgt_pc;
      if (state_q == WAIT) begin
        // Read still in flight: its response must be dropped when it lands.
        discard_d = !fq.imem_valid_i;
        state_d   = fq.imem_valid_i ? RUN : WAIT;
      end
      if (tgt_bad) begin
        err_d   = 1'b1;
        state_d = HALT;
      end
    end else begin
      if (resp) begin
        discard_d = 1'b0;
      end
      if (push) begin
        fifo_d[wr_ptr_q] = '{instr: fq.imem_instr_i, pc: req_pc_q};
        wr_ptr_d         = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);

      unique case (state_q)
        IDLE: if (start_i) state_d = RUN;
        RUN, WAIT: begin
          if ((state_q == RUN) || resp) begin
            if (can_issue) begin
              req        = 1'b1;
              req_pc_d   = fetch_pc_q;
              fetch_pc_d = fetch_pc_q + 32'd4;
              state_d    = WAIT;
            end else begin
              state_d = RUN;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      discard_q  <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      discard_q  <= discard_d;
      err_q      <= err_d;
      fifo_q     <= fifo_d;
    end
  end

  assign head            = fifo_q[rd_ptr_q];
  assign fq.imem_req_o   = req;
  assign fq.imem_addr_o  = fetch_pc_q;
  assign fq.inst_valid_o = inst_vld;
  assign fq.inst_o       = inst_vld ? head.instr : 32'd0;
  assign fq.inst_pc_o    = inst_vld ? head.pc : 32'd0;
  assign fq.inst_pc4_o   = fq.inst_pc_o + 32'd4;
  assign err_o           = err_q;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized memory latency / consumer stalls / redirects against a transaction-level model
// (expected PC stream, occupancy count, single outstanding read) plus directed scenarios.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        err_o;

  fetch_queue_if fq_if ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .fq           (fq_if),
    .err_o        (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: what the fetch stage should look like from outside.
  bit          m_running, m_halted, m_err;
  int          m_cnt;
  logic [31:0] m_req_pc, m_next_pc;
  // Memory responder state (one read in flight).
  bit          pend_active, pend_stale;
  logic [31:0] pend_addr;
  int          pend_cyc, cyc, lat_lo, lat_hi;
  // Per-cycle drive values.
  bit          drv_start, drv_redirect, drv_ready;
  logic [31:0] drv_rpc;
  // Observations.
  int          n_req, n_pop, last_req_cyc, first_req_cyc, first_valid_cyc;
  logic [31:0] last_req_addr, last_pop_pc;

  task automatic cycle();
    bit resp, redir, push, pop, exp_vld, exp_req;
    @(negedge clk_i);
    resp = pend_active && (cyc == pend_cyc);
    fq_if.imem_valid_i = resp;
    fq_if.imem_instr_i = resp ? ~pend_addr : 32'($urandom);
    start_i = drv_start;
    redirect_i = drv_redirect;
    redirect_pc_i = drv_rpc;
    fq_if.inst_ready_i = drv_ready;
    #1;
    redir = drv_redirect && !m_halted;
    push  = resp && !pend_stale && !redir;
    if (resp) pend_active = 1'b0;
    exp_vld = (m_cnt > 0) && !m_halted;
    pop = exp_vld && drv_ready;
    check_eq("inst_valid", 32'(fq_if.inst_valid_o), 32'(exp_vld));
    if (exp_vld) begin
      check_eq("inst_pc", fq_if.inst_pc_o, m_next_pc);
      check_eq("inst", fq_if.inst_o, ~m_next_pc);
      check_eq("inst_pc4", fq_if.inst_pc4_o, m_next_pc + 32'd4);
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    check_eq("err", 32'(err_o), 32'(m_err));
    exp_req = m_running && !m_halted && !redir && !pend_active && ((m_cnt + int'(push)) < DEPTH);
    check_eq("imem_req", 32'(fq_if.imem_req_o), 32'(exp_req));
    if (exp_req) begin
      check_eq("imem_addr", fq_if.imem_addr_o, m_req_pc);
      m_req_pc = m_req_pc + 32'd4;
    end
    if (fq_if.imem_req_o) begin
      n_req++;
      last_req_cyc  = cyc;
      last_req_addr = fq_if.imem_addr_o;
      if (first_req_cyc < 0) first_req_cyc = cyc;
      pend_active = 1'b1;
      pend_stale  = 1'b0;
      pend_addr   = fq_if.imem_addr_o;
      pend_cyc    = cyc + int'($urandom_range(lat_hi, lat_lo));
    end
    if (redir) begin
      m_cnt     = 0;
      m_req_pc  = {drv_rpc[31:2], 2'b00};
      m_next_pc = m_req_pc;
      if (pend_active) pend_stale = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
      if (drv_rpc[1:0] != 2'b00) begin
        m_halted = 1'b1;
        m_err    = 1'b1;
      end
`endif
    end else begin
      m_cnt = m_cnt + int'(push) - int'(pop);
      if (pop) begin
        n_pop++;
        last_pop_pc = fq_if.inst_pc_o;
        m_next_pc   = m_next_pc + 32'd4;
      end
      if (!m_running && drv_start) m_running = 1'b1;
    end
    cyc++;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    drv_redirect = 1'b1;
    drv_rpc      = pc;
    cycle();
    drv_redirect = 1'b0;
  endtask

  // Called between cycles: reset drops asynchronously before the next edge.
  task automatic do_reset();
    #1;
    rst_i = 1'b0;
    #1;
    check_eq("rst_imem_req", 32'(fq_if.imem_req_o), 32'd0);
    check_eq("rst_imem_addr", fq_if.imem_addr_o, RESET_PC);
    check_eq("rst_inst_valid", 32'(fq_if.inst_valid_o), 32'd0);
    check_eq("rst_inst", fq_if.inst_o, 32'd0);
    check_eq("rst_inst_pc", fq_if.inst_pc_o, 32'd0);
    check_eq("rst_inst_pc4", fq_if.inst_pc4_o, 32'd4);
    check_eq("rst_err", 32'(err_o), 32'd0);
    m_running = 1'b0;
    m_halted  = 1'b0;
    m_err     = 1'b0;
    m_cnt     = 0;
    m_req_pc  = RESET_PC;
    m_next_pc = RESET_PC;
    if (pend_active) pend_stale = 1'b1;
    drv_start    = 1'b0;
    drv_redirect = 1'b0;
    cycle();
    rst_i = 1'b1;
  endtask

  initial begin
    int  p0, r0, c0, start_cyc;
    bit  found;
    logic [31:0] rpc;
    rst_i = 1'b0;
    start_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 32'd0;
    fq_if.imem_valid_i = 1'b0;
    fq_if.imem_instr_i = 32'd0;
    fq_if.inst_ready_i = 1'b0;
    drv_start = 0; drv_redirect = 0; drv_ready = 0; drv_rpc = 32'd0;
    pend_active = 0; pend_stale = 0; pend_addr = 32'd0; pend_cyc = 0; cyc = 0;
    lat_lo = 1; lat_hi = 1;
    n_req = 0; n_pop = 0; last_req_cyc = -1; first_req_cyc = -1; first_valid_cyc = -1;
    last_req_addr = 32'd0; last_pop_pc = 32'd0;
    @(negedge clk_i);
    #1;
    do_reset();

    // 1-cycle memory, always-ready consumer: latency and throughput.
    drv_ready = 1'b1;
    drv_start = 1'b1;
    start_cyc = cyc;
    first_req_cyc = -1;
    first_valid_cyc = -1;
    for (int i = 0; i < 8; i++) cycle();
    check_eq("first_req_cycle", 32'(first_req_cyc), 32'(start_cyc + 1));
    check_eq("req_to_valid", 32'(first_valid_cyc - first_req_cyc), 32'd2);
    p0 = n_pop;
    for (int i = 0; i < 16; i++) cycle();
    check_eq("throughput", 32'(n_pop - p0), 32'd16);
    drv_start = 1'b0;

    // Stalled consumer: exactly DEPTH requests, then one per pop.
    drv_ready = 1'b0;
    redirect_to(32'h0000_0200);
    r0 = n_req;
    for (int i = 0; i < 20; i++) cycle();
    check_eq("full_req_count", 32'(n_req - r0), 32'(DEPTH));
    drv_ready = 1'b1;
    cycle();
    drv_ready = 1'b0;
    r0 = n_req;
    c0 = cyc;
    for (int i = 0; i < 6; i++) cycle();
    check_eq("req_after_pop", 32'(n_req - r0), 32'd1);
    check_eq("req_after_pop_cyc", 32'(last_req_cyc), 32'(c0));

    // 3-cycle memory, redirect in the middle of a read.
    drv_ready = 1'b1;
    lat_lo = 3; lat_hi = 3;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (pend_active && (pend_cyc - cyc == 2)) begin
        found = 1'b1;
        redirect_to(32'h0000_0100);
      end else begin
        cycle();
      end
    end
    check_eq("mid_read_window", 32'(found), 32'd1);
    p0 = n_pop;
    for (int i = 0; i < 20 && n_pop == p0; i++) cycle();
    check_eq("post_redirect_pop", 32'(n_pop > p0), 32'd1);
    check_eq("post_redirect_pc", last_pop_pc, 32'h0000_0100);

    // Redirect coincident with a response and a pop.
    lat_lo = 1; lat_hi = 1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (pend_active && (pend_cyc == cyc) && (m_cnt > 0)) begin
        found = 1'b1;
        redirect_to(32'h0000_0300);
      end else begin
        cycle();
      end
    end
    check_eq("coincident_window", 32'(found), 32'd1);
    cycle();
    check_eq("coincident_next_addr", last_req_addr, 32'h0000_0300);
    check_eq("coincident_next_cyc", 32'(last_req_cyc), 32'(cyc - 1));

    // Reset while a 3-cycle read is outstanding.
    lat_lo = 3; lat_hi = 3;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (pend_active && (cyc < pend_cyc)) found = 1'b1;
      else cycle();
    end
    check_eq("wait_window", 32'(found), 32'd1);
    do_reset();
    for (int i = 0; i < 6; i++) cycle();
    drv_start = 1'b1;
    r0 = n_req;
    for (int i = 0; i < 6 && n_req == r0; i++) cycle();
    drv_start = 1'b0;
    check_eq("restart_req_seen", 32'(n_req > r0), 32'd1);
    check_eq("restart_addr", last_req_addr, RESET_PC);

    // Random latency, stalls and aligned redirects.
    for (int i = 0; i < 400; i++) begin
      if ((i % 50) == 0) begin
        lat_lo = 1;
        lat_hi = int'($urandom_range(3, 1));
      end
      drv_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(24, 0) == 0) begin
        rpc = $urandom;
        rpc[1:0] = 2'b00;
        redirect_to(rpc);
      end else begin
        cycle();
      end
    end

    // Misaligned redirect.
    drv_ready = 1'b1;
    redirect_to(32'h0000_0102);
    r0 = n_req;
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 10; i++) cycle();
    check_eq("halt_no_req", 32'(n_req - r0), 32'd0);
    check_eq("halt_err", 32'(err_o), 32'd1);
`else
    for (int i = 0; i < 10 && n_req == r0; i++) cycle();
    check_eq("misalign_req_seen", 32'(n_req > r0), 32'd1);
    check_eq("misalign_addr", last_req_addr, 32'h0000_0100);
    check_eq("misalign_err", 32'(err_o), 32'd0);
`endif
    for (int i = 0; i < 4; i++) cycle();
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage sitting directly upstream of the single-cycle datapath. It owns the fetch PC and issues word reads to an instruction memory with variable response latency. It buffers returned instructions, each tagged with its PC, in a small FIFO and hands them to the datapath over a valid/ready handshake. A branch or jump redirect from the datapath flushes the buffer and any in-flight read.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  level; fetching begins when sampled high in IDLE
- redirect_i  in  1  one-cycle pulse: flush and restart at redirect_pc_i
- redirect_pc_i  in  32  new fetch PC (branch/jump target)
- imem_req_o  out  1  one-cycle read request strobe
- imem_addr_o  out  32  read address; valid when imem_req_o=1
- imem_valid_i  in  1  one-cycle response strobe, ≥1 cycle after request
- imem_instr_i  in  32  response data, valid with imem_valid_i
- inst_valid_o  out  1  FIFO head holds an instruction
- inst_ready_i  in  1  consumer accepts head this cycle
- inst_o  out  32  head instruction
- inst_pc_o  out  32  PC of head instruction
- inst_pc4_o  out  32  inst_pc_o + 4 (mod 2^32)
- err_o  out  1  sticky misaligned-redirect error (see Configuration)

## Operation
- States: IDLE, RUN (no read outstanding), WAIT (one read outstanding), HALT.
- At most one outstanding read, ever.
- IDLE → RUN when start_i=1; start_i ignored in other states.
- Issue rule (RUN, or WAIT in the cycle imem_valid_i=1): assert imem_req_o with imem_addr_o=fetch_pc, fetch_pc += 4, next state WAIT, provided count_q + push < DEPTH, where push=1 if a response is written this cycle. A same-cycle pop is not credited. Otherwise WAIT→RUN on response, or stay RUN.
- Response in WAIT: if discard flag clear, write {imem_instr_i, request PC} at tail; else drop it and clear discard.
- Pop: inst_valid_o & inst_ready_i removes the head.
- Simultaneous push and pop on a non-empty FIFO: count unchanged. Push to an empty FIFO appears on the next cycle (no bypass).
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Redirect (any state except HALT):
  - count=0, pointers reset, fetch_pc=redirect_pc_i.
  - No request is issued that cycle.
  - If in WAIT and no response arrives this cycle, set discard.
  - A response arriving in the redirect cycle is dropped.
  - A same-cycle pop is consumed and discarded along with the flush.
  - In IDLE, only fetch_pc updates; the state remains IDLE.
- Responses outside WAIT are ignored.

## Timing
- Reset values:
  - state=IDLE, fetch_pc=RESET_PC, count=0, discard=0
  - imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0
  - inst_o=0, inst_pc_o=0, inst_pc4_o=4, err_o=0
- Reset mid-read: the outstanding read is forgotten; its response arrives in IDLE and is ignored.
- start_i high at edge E0 → RUN; imem_req_o high in the cycle after E0.
- With 1-cycle memory: request in cycle N, imem_valid_i in N+1, inst_valid_o in N+2.
- Steady state is one instruction per cycle when the consumer is always ready.
- Redirect at edge E: a request for redirect_pc_i in cycle E+1; inst_valid_o=0 from E+1 until the new data is written.
- Full (count=DEPTH): no requests; resumes the cycle after the first pop.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc_i[1:0]≠0 flushes as normal, sets err_o=1 (sticky until reset), and enters HALT.
  - In HALT: no requests, inst_valid_o=0, all inputs ignored.
- Undefined:
  - redirect_pc_i[1:0] is forced to 2'b00.
  - err_o is tied 0 and HALT is unreachable.

## Test plan
- Reset, start_i=1, 1-cycle memory returning addr^32'hFFFF_FFFF, inst_ready_i=1 → requests at 0,4,8,…; inst_pc_o 0,4,8 on consecutive cycles; inst_o matches; first inst_valid_o 2 cycles after first request.
- inst_ready_i=0, DEPTH=4 → exactly 4 requests then imem_req_o stays 0; one pop → exactly one new request the next cycle.
- 3-cycle memory latency, redirect_i to 32'h100 in the middle cycle of a read → stale response dropped, FIFO empty, next delivered inst_pc_o=32'h100.
- Redirect coincident with imem_valid_i and a pop → response dropped, count=0, next request addr=redirect target.
- rst_i asserted low mid-WAIT for 1 cycle → all outputs at reset values immediately; late response ignored; restart fetches from RESET_PC.
- Redirect to 32'h102: with FETCH_ALIGN_CHECK_EN → err_o=1, no further requests; without → fetch from 32'h100, err_o=0.
